// File: rtl/palette_pkg.sv
// Shared pipe-5 definitions: palette word width, default FIFO depth, RGB888 pixel type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package palette_pkg;

    localparam int PALETTE_DATA_W      = 24;
    localparam int PALETTE_FIFO_ADDR_W = 3;

    // Palette-resolved pixel as handed between pipe-5 stages.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

endpackage

// File: rtl/palette_fifo_mem.sv
// Palette FIFO storage: 2**ADDR_W x DATA_W array, one write port, one registered read port.
// Latency: read data appears one cycle after rd_en; writes land on the same edge.
// Backpressure: none; the caller only issues legal reads/writes.
//
// Ports: clk, reset (async active-low, read register only), clr (sync zero of read register),
//        wr_en/wr_addr/wr_data, rd_en/rd_addr, rd_data (registered).
module palette_fifo_mem
    import palette_pkg::*;
#(
    parameter int DATA_W = PALETTE_DATA_W,
    parameter int ADDR_W = PALETTE_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // No reset on the array so it can map onto block RAM.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register is resettable; a same-address write in the same cycle
    // is not forwarded, so the read returns the old word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/palette_fifo_sync.sv
// Single-clock palette FIFO between palette lookup and scan-out, with level and thresholds.
// Latency: 1 cycle write-to-readable, 1 cycle read_en-to-data_out/out_valid.
// Backpressure: writes refused when full (unless a read is accepted the same cycle); reads ignored when empty.
//
// Ports: clk, reset (async active-low), flush (sync clear), write_en/data_in, read_en,
//        data_out (held) + out_valid pulse, level, empty, full, almost_empty, almost_full,
//        overflow/underflow (sticky, only when PALETTE_FIFO_ERR_EN is defined).
module palette_fifo_sync
    import palette_pkg::*;
#(
    parameter int DATA_W        = PALETTE_DATA_W,
    parameter int ADDR_W        = PALETTE_FIFO_ADDR_W,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              write_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_en,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full
`ifdef PALETTE_FIFO_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam logic [ADDR_W:0] AF_T = AFULL_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_T = AEMPTY_THRESH[ADDR_W:0];

    // MSB of each pointer is the wrap bit; low bits address storage.
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            rd_acc;
    logic            wr_acc;

    assign level        = wr_ptr - rd_ptr;
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                          (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign almost_empty = (level <= AE_T);
    assign almost_full  = (level >= AF_T);

    // A write into a full FIFO is fine when a read frees a slot on the same edge.
    assign rd_acc = read_en & ~empty;
    assign wr_acc = write_en & (~full | rd_acc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            out_valid <= rd_acc;
        end
    end

    palette_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .clr     (flush),
        .wr_en   (wr_acc & ~flush),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_acc & ~flush),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (data_out)
    );

`ifdef PALETTE_FIFO_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_en & ~wr_acc) begin
                overflow <= 1'b1;
            end
            if (read_en & empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_palette_fifo_sync.sv
// Directed bench for palette_fifo_sync with default parameters.
// Latency: inputs applied after an edge, outputs sampled 1 time unit after the next edge.
// Backpressure: exercised via full/empty corner sequences.
module tb_palette_fifo_sync;
    import palette_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        write_en;
    logic [23:0] data_in;
    logic        read_en;
    logic [23:0] data_out;
    logic        out_valid;
    logic [3:0]  level;
    logic        empty;
    logic        full;
    logic        almost_empty;
    logic        almost_full;
`ifdef PALETTE_FIFO_ERR_EN
    logic        overflow;
    logic        underflow;
`endif

    always #5 clk = ~clk;

    palette_fifo_sync dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .write_en     (write_en),
        .data_in      (data_in),
        .read_en      (read_en),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full)
`ifdef PALETTE_FIFO_ERR_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    typedef struct {
        logic        f;
        logic        w;
        logic        r;
        logic [23:0] din;
        logic [23:0] dout;
        logic        vld;
        logic [3:0]  lvl;
        logic        e;
        logic        fu;
        logic        ae;
        logic        af;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic f, input logic w, input logic r, input logic [23:0] d);
        flush    = f;
        write_en = w;
        read_en  = r;
        data_in  = d;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [23:0] dout, input logic vld,
                               input logic [3:0] lvl, input logic e, input logic fu,
                               input logic ae, input logic af);
        chk({tag, ".data_out"},     data_out,     dout);
        chk({tag, ".out_valid"},    out_valid,    vld);
        chk({tag, ".level"},        level,        lvl);
        chk({tag, ".empty"},        empty,        e);
        chk({tag, ".full"},         full,         fu);
        chk({tag, ".almost_empty"}, almost_empty, ae);
        chk({tag, ".almost_full"},  almost_full,  af);
    endtask

    function automatic vec_t mk(input logic f, input logic w, input logic r, input logic [23:0] din,
                                input logic [23:0] dout, input logic vld, input logic [3:0] lvl,
                                input logic e, input logic fu, input logic ae, input logic af);
        vec_t v;
        v.f = f; v.w = w; v.r = r; v.din = din; v.dout = dout; v.vld = vld;
        v.lvl = lvl; v.e = e; v.fu = fu; v.ae = ae; v.af = af;
        return v;
    endfunction

    vec_t         vecs[$];
    logic [23:0]  sb[$];
    logic [23:0]  exp_word;

    initial begin
        //           f  w  r  din        dout       vld lvl e  fu ae af
        vecs.push_back(mk(0, 1, 0, 24'h000001, 24'h000000, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 24'h000002, 24'h000000, 0, 2, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 24'h000003, 24'h000000, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 24'h000004, 24'h000000, 0, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 24'h000005, 24'h000000, 0, 5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 24'h000006, 24'h000000, 0, 6, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 24'h000007, 24'h000000, 0, 7, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 24'h000008, 24'h000000, 0, 8, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 24'h000000, 24'h000001, 1, 7, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 24'h000000, 24'h000002, 1, 6, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 24'h000000, 24'h000003, 1, 5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 24'h000000, 24'h000004, 1, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 24'h000000, 24'h000005, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 24'h000000, 24'h000006, 1, 2, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 24'h000000, 24'h000007, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 24'h000000, 24'h000008, 1, 0, 1, 0, 1, 0));
        // idle: data held, valid drops; extra read of empty is ignored
        vecs.push_back(mk(0, 0, 0, 24'h000000, 24'h000008, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 24'h000000, 24'h000008, 0, 0, 1, 0, 1, 0));

        reset    = 1'b0;
        flush    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        data_in  = '0;
        #12;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_state("reset", 24'h0, 0, 4'd0, 1, 0, 1, 0);
`ifdef PALETTE_FIFO_ERR_EN
        chk("reset.overflow",  overflow,  1'b0);
        chk("reset.underflow", underflow, 1'b0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].f, vecs[i].w, vecs[i].r, vecs[i].din);
            check_state($sformatf("vec%0d", i), vecs[i].dout, vecs[i].vld, vecs[i].lvl,
                        vecs[i].e, vecs[i].fu, vecs[i].ae, vecs[i].af);
        end
`ifdef PALETTE_FIFO_ERR_EN
        chk("vec.underflow_after_empty_read", underflow, 1'b1);
        step(1, 0, 0, 24'h0);
        chk("flush_clears.underflow", underflow, 1'b0);
`endif

        // Fill, then write into full without a read.
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 24'h000010 + 24'(i));
            sb.push_back(24'h000010 + 24'(i));
        end
        chk("fill.full", full, 1'b1);
        step(0, 1, 0, 24'hABCDEF);
        chk("ovf.level", level, 4'd8);
        chk("ovf.full",  full,  1'b1);
`ifdef PALETTE_FIFO_ERR_EN
        chk("ovf.overflow", overflow, 1'b1);
        step(0, 0, 0, 24'h0);
        chk("ovf.overflow_sticky", overflow, 1'b1);
`endif

        // Full with simultaneous read+write: level pinned at 8, order kept, pointers wrap.
        for (int j = 0; j < 20; j++) begin
            exp_word = sb.pop_front();
            sb.push_back(24'h000100 + 24'(j));
            step(0, 1, 1, 24'h000100 + 24'(j));
            chk($sformatf("rw%0d.data_out", j),  data_out,  exp_word);
            chk($sformatf("rw%0d.out_valid", j), out_valid, 1'b1);
            chk($sformatf("rw%0d.level", j),     level,     4'd8);
        end

        // Drain to level 3.
        for (int j = 0; j < 5; j++) begin
            exp_word = sb.pop_front();
            step(0, 0, 1, 24'h0);
            chk($sformatf("drain%0d.data_out", j), data_out, exp_word);
        end
        chk("drain.level", level, 4'd3);

        // Flush beats a concurrent read.
        step(1, 0, 1, 24'h0);
        check_state("flush", 24'h0, 0, 4'd0, 1, 0, 1, 0);
`ifdef PALETTE_FIFO_ERR_EN
        chk("flush.overflow", overflow, 1'b0);
`endif

        // Read of empty with same-cycle write: no bypass.
        step(0, 1, 1, 24'h123456);
        chk("nobyp.out_valid", out_valid, 1'b0);
        chk("nobyp.level",     level,     4'd1);
        chk("nobyp.data_out",  data_out,  24'h0);
`ifdef PALETTE_FIFO_ERR_EN
        chk("nobyp.underflow", underflow, 1'b1);
`endif
        step(0, 0, 1, 24'h0);
        chk("nobyp_rd.data_out",  data_out,  24'h123456);
        chk("nobyp_rd.out_valid", out_valid, 1'b1);
        chk("nobyp_rd.empty",     empty,     1'b1);

        // Asynchronous reset mid-operation, asserted between edges.
        step(0, 1, 0, 24'h00AAAA);
        step(0, 1, 0, 24'h00BBBB);
        chk("pre_arst.level", level, 4'd2);
        #2;
        reset = 1'b0;
        #1;
        check_state("arst", 24'h0, 0, 4'd0, 1, 0, 1, 0);
        #2;
        reset = 1'b1;
        step(0, 0, 0, 24'h0);
        check_state("post_arst", 24'h0, 0, 4'd0, 1, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
